// File: rtl/obi_sram_arbiter.sv
// Round-robin arbiter sharing one single-port OBI SRAM subordinate among NumReq managers.
// Zero added latency on the request path; responses return Latency cycles after the handshake.
// A stalled request is locked and held stable until granted; responses are never back-pressured.
// Optional build macro OBI_SRAM_ARB_FIXED_PRIO_EN: lowest index wins in IDLE and no rr_q is kept.
module obi_sram_arbiter #(
  parameter int NumReq    = 2,
  parameter int DataWidth = 32,
  parameter int Latency   = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               req_i,
  output logic [NumReq-1:0]               gnt_o,
  input  logic [NumReq*32-1:0]            addr_i,
  input  logic [NumReq-1:0]               we_i,
  input  logic [NumReq*(DataWidth/8)-1:0] be_i,
  input  logic [NumReq*DataWidth-1:0]     wdata_i,
  output logic [NumReq-1:0]               rvalid_o,
  output logic [NumReq*DataWidth-1:0]     rdata_o,
  output logic                            sbr_req_o,
  input  logic                            sbr_gnt_i,
  output logic [31:0]                     sbr_addr_o,
  output logic                            sbr_we_o,
  output logic [DataWidth/8-1:0]          sbr_be_o,
  output logic [DataWidth-1:0]            sbr_wdata_o,
  input  logic                            sbr_rvalid_i,
  input  logic [DataWidth-1:0]            sbr_rdata_i,
  output logic                            resp_err_o
);

  localparam int BeWidth = DataWidth / 8;
  localparam int IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] lock_q;
  logic [IdxW-1:0] winner;
  logic            win_vld;
  logic            hs;
  logic            err_q;

  logic [Latency-1:0] own_vld_q;
  logic [IdxW-1:0]    own_idx_q [Latency];
  logic               tail_vld;
  logic [IdxW-1:0]    tail_idx;

`ifndef OBI_SRAM_ARB_FIXED_PRIO_EN
  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] cand;
`endif

  // Winner selection: locked owner, otherwise next requester after the last grant
  always_comb begin
    winner  = '0;
    win_vld = 1'b0;
`ifndef OBI_SRAM_ARB_FIXED_PRIO_EN
    cand    = '0;
`endif
    if (state_q == LOCKED) begin
      winner  = lock_q;
      win_vld = req_i[lock_q];
    end else begin
`ifdef OBI_SRAM_ARB_FIXED_PRIO_EN
      // Walk downwards so the lowest set index is the one left standing
      for (int i = NumReq - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          winner  = IdxW'(i);
          win_vld = 1'b1;
        end
      end
`else
      // Walk the ring backwards from rr_q so the nearest requester after rr_q wins
      for (int i = NumReq; i >= 1; i--) begin
        cand = IdxW'((int'(rr_q) + i) % NumReq);
        if (req_i[cand]) begin
          winner  = cand;
          win_vld = 1'b1;
        end
      end
`endif
    end
  end

  // A dropped locked request (protocol violation) yields no grant and pushes no owner
  assign hs = win_vld & sbr_gnt_i;

  // FSM state, lock owner and round-robin pointer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
`ifndef OBI_SRAM_ARB_FIXED_PRIO_EN
      rr_q    <= IdxW'(NumReq - 1);
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && win_vld && !sbr_gnt_i) lock_q <= winner;
`ifndef OBI_SRAM_ARB_FIXED_PRIO_EN
      if (hs) rr_q <= winner;
`endif
    end
  end

  // Next state: lock on a stalled request, release on grant or on request withdrawal
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld && !sbr_gnt_i) state_d = LOCKED;
      LOCKED:  if (!win_vld || sbr_gnt_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request-path outputs: forward the winner combinationally, grant only the winner
  always_comb begin
    gnt_o       = '0;
    if (hs) gnt_o[winner] = 1'b1;
    sbr_req_o   = |req_i;
    sbr_addr_o  = addr_i[32*int'(winner) +: 32];
    sbr_we_o    = we_i[winner];
    sbr_be_o    = be_i[BeWidth*int'(winner) +: BeWidth];
    sbr_wdata_o = wdata_i[DataWidth*int'(winner) +: DataWidth];
  end

  // Owner pipe: one {valid, idx} entry per cycle, aligned with the subordinate latency
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      own_vld_q <= '0;
      for (int i = 0; i < Latency; i++) own_idx_q[i] <= '0;
    end else begin
      own_vld_q[0] <= hs;
      own_idx_q[0] <= winner;
      for (int i = 1; i < Latency; i++) begin
        own_vld_q[i] <= own_vld_q[i-1];
        own_idx_q[i] <= own_idx_q[i-1];
      end
    end
  end

  assign tail_vld = own_vld_q[Latency-1];
  assign tail_idx = own_idx_q[Latency-1];

  // Response routing: only the recorded owner sees rvalid/rdata, unowned data is dropped
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (tail_vld && sbr_rvalid_i) begin
      rvalid_o[tail_idx]                             = 1'b1;
      rdata_o[DataWidth*int'(tail_idx) +: DataWidth] = sbr_rdata_i;
    end
  end

  // Sticky error when a response and its expected slot disagree
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (sbr_rvalid_i != tail_vld) err_q <= 1'b1;
  end

  assign resp_err_o = err_q;

endmodule

// File: tb/tb_obi_sram_arbiter.sv
// Testbench for obi_sram_arbiter: directed scenarios plus randomized traffic.
// A transaction-level model predicts grants, forwarded fields and routed responses.
// The bench also plays the subordinate, returning data LAT cycles after each handshake.
module tb_obi_sram_arbiter;
  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LAT = 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    req_i, gnt_o, we_i, rvalid_o;
  logic [N*32-1:0] addr_i;
  logic [N*BW-1:0] be_i;
  logic [N*DW-1:0] wdata_i, rdata_o;
  logic            sbr_req_o, sbr_gnt_i, sbr_we_o, sbr_rvalid_i, resp_err_o;
  logic [31:0]     sbr_addr_o;
  logic [BW-1:0]   sbr_be_o;
  logic [DW-1:0]   sbr_wdata_o, sbr_rdata_i;

  obi_sram_arbiter #(.NumReq(N), .DataWidth(DW), .Latency(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .sbr_req_o(sbr_req_o), .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(sbr_addr_o), .sbr_we_o(sbr_we_o),
    .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o), .sbr_rvalid_i(sbr_rvalid_i),
    .sbr_rdata_i(sbr_rdata_i), .resp_err_o(resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: list of outstanding transfers stamped with the cycle their response is due
  typedef struct { int due; int idx; } resp_t;
  resp_t pend[$];
  int    m_last, m_lock, cyc = 0, e_win;
  bit    m_err;

  logic [N-1:0]    e_gnt, e_rvalid;
  logic [N*DW-1:0] e_rdata;

  function automatic bit due_now();
    return (pend.size() > 0) && (pend[0].due == cyc);
  endfunction

  function automatic int model_winner();
    if (m_lock >= 0) return req_i[m_lock] ? m_lock : -1;
`ifdef OBI_SRAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (req_i[k]) return k;
`else
    for (int k = 1; k <= N; k++) if (req_i[(m_last + k) % N]) return (m_last + k) % N;
`endif
    return -1;
  endfunction

  task automatic predict();
    e_win = model_winner();
    e_gnt = '0;
    if (e_win >= 0 && sbr_gnt_i) e_gnt[e_win] = 1'b1;
    e_rvalid = '0;
    e_rdata  = '0;
    if (due_now() && sbr_rvalid_i) begin
      e_rvalid[pend[0].idx]           = 1'b1;
      e_rdata[pend[0].idx*DW +: DW]   = sbr_rdata_i;
    end
  endtask

  task automatic advance();
    bit d;
    d = due_now();
    if (sbr_rvalid_i != d) m_err = 1'b1;
    if (d) void'(pend.pop_front());
    if (e_win >= 0 && sbr_gnt_i) begin
      pend.push_back('{cyc + LAT, e_win});
      m_last = e_win;
      m_lock = -1;
    end else if (e_win >= 0) begin
      m_lock = e_win;
    end else begin
      m_lock = -1;
    end
    @(posedge clk_i);
    cyc++;
    #1;
  endtask

  task automatic drive_resp();
    sbr_rvalid_i = due_now();
    sbr_rdata_i  = $urandom;
  endtask

  task automatic do_reset();
    req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
    sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b0; sbr_rdata_i = '0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    pend.delete();
    m_last = N - 1;
    m_lock = -1;
    m_err  = 1'b0;
  endtask

  task automatic test_reset();
    req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b0;
    rst_i = 1'b1;
    #2;
    checks++;
    if ({gnt_o, rvalid_o, rdata_o, sbr_req_o, resp_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b rvalid=%b rdata=%h req=%b err=%b want all 0",
               gnt_o, rvalid_o, rdata_o, sbr_req_o, resp_err_o);
    end
    do_reset();
  endtask

  task automatic test_alternate();
    int exp_seq[4];
`ifdef OBI_SRAM_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    do_reset();
    sbr_gnt_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_i  = (c < 4) ? 2'b11 : 2'b00;
      addr_i = {$urandom, $urandom};
      drive_resp();
      @(negedge clk_i);
      predict();
      if (c < 4) begin
        checks++;
        if (gnt_o !== (2'b01 << exp_seq[c])) begin
          errors++;
          $display("FAIL alt_gnt c=%0d got %b want %b", c, gnt_o, 2'b01 << exp_seq[c]);
        end
        checks++;
        if (sbr_addr_o !== addr_i[exp_seq[c]*32 +: 32]) begin
          errors++;
          $display("FAIL alt_addr c=%0d got %h want %h", c, sbr_addr_o, addr_i[exp_seq[c]*32 +: 32]);
        end
      end
      if (c > 0) begin
        checks++;
        if (rvalid_o !== (2'b01 << exp_seq[c-1]) || rdata_o !== e_rdata) begin
          errors++;
          $display("FAIL alt_resp c=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                   c, rvalid_o, rdata_o, 2'b01 << exp_seq[c-1], e_rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_single();
    do_reset();
    sbr_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req_i  = (c < 3) ? 2'b01 : 2'b00;
      addr_i = {$urandom, $urandom};
      drive_resp();
      @(negedge clk_i);
      predict();
      checks++;
      if (gnt_o !== e_gnt || (c < 3 && gnt_o !== 2'b01)) begin
        errors++;
        $display("FAIL single_gnt c=%0d got %b want %b", c, gnt_o, e_gnt);
      end
      checks++;
      if (rvalid_o !== ((c > 0) ? 2'b01 : 2'b00) || rdata_o[DW +: DW] !== '0 || rdata_o !== e_rdata) begin
        errors++;
        $display("FAIL single_resp c=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                 c, rvalid_o, rdata_o, e_rvalid, e_rdata);
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [31:0] a0;
    do_reset();
    a0 = 32'h0000_1000;
    for (int c = 0; c < 6; c++) begin
      sbr_gnt_i = (c >= 3);
      req_i     = (c == 0) ? 2'b01 : (c < 4) ? 2'b11 : (c == 4) ? 2'b10 : 2'b00;
      addr_i    = {$urandom, a0};
      drive_resp();
      @(negedge clk_i);
      predict();
      if (c < 4) begin
        checks++;
        if (sbr_addr_o !== a0) begin
          errors++;
          $display("FAIL stall_addr c=%0d got %h want %h", c, sbr_addr_o, a0);
        end
      end
      checks++;
      if (gnt_o !== e_gnt || gnt_o !== ((c == 3) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL stall_gnt c=%0d got %b want %b", c, gnt_o, e_gnt);
      end
      checks++;
      if (rvalid_o !== e_rvalid) begin
        errors++;
        $display("FAIL stall_rvalid c=%0d got %b want %b", c, rvalid_o, e_rvalid);
      end
      advance();
    end
  endtask

  task automatic test_read_resp();
    do_reset();
    sbr_gnt_i = 1'b1;
    req_i = 2'b10; we_i = 2'b00; addr_i = {32'h8, 32'h0};
    drive_resp();
    @(negedge clk_i);
    predict();
    checks++;
    if (gnt_o !== 2'b10 || sbr_addr_o !== 32'h8 || sbr_we_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_req got gnt=%b addr=%h we=%b want 10/00000008/0", gnt_o, sbr_addr_o, sbr_we_o);
    end
    advance();
    req_i = 2'b00; sbr_rvalid_i = 1'b1; sbr_rdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    predict();
    checks++;
    if (rvalid_o !== 2'b10 || rdata_o !== {32'hCAFEF00D, 32'h0}) begin
      errors++;
      $display("FAIL rd_resp got rvalid=%b rdata=%h want 10/cafef00d00000000", rvalid_o, rdata_o);
    end
    advance();
    sbr_rvalid_i = 1'b0;
    @(negedge clk_i);
    predict();
    checks++;
    if (resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_err got %b want 0", resp_err_o);
    end
    advance();
  endtask

  task automatic test_unowned();
    do_reset();
    sbr_rvalid_i = 1'b1; sbr_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    predict();
    checks++;
    if (rvalid_o !== 2'b00 || rdata_o !== '0) begin
      errors++;
      $display("FAIL unowned_drop got rvalid=%b rdata=%h want 00/0", rvalid_o, rdata_o);
    end
    advance();
    sbr_rvalid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      predict();
      checks++;
      if (resp_err_o !== 1'b1 || resp_err_o !== m_err) begin
        errors++;
        $display("FAIL unowned_sticky c=%0d got %b want 1", c, resp_err_o);
      end
      advance();
    end
    do_reset();
    #1;
    checks++;
    if (resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL unowned_clear got %b want 0", resp_err_o);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    sbr_gnt_i = 1'b1; req_i = 2'b01; addr_i = {$urandom, $urandom};
    drive_resp();
    @(negedge clk_i);
    predict();
    advance();
    req_i = 2'b00; sbr_rvalid_i = 1'b0;
    do_reset();
    sbr_gnt_i = 1'b1;
    @(negedge clk_i);
    predict();
    checks++;
    if (rvalid_o !== 2'b00 || resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL inflight_flush got rvalid=%b err=%b want 00/0", rvalid_o, resp_err_o);
    end
    advance();
    req_i = 2'b11;
    drive_resp();
    @(negedge clk_i);
    predict();
    checks++;
    if (gnt_o !== 2'b01 || gnt_o !== e_gnt) begin
      errors++;
      $display("FAIL inflight_first got %b want 01", gnt_o);
    end
    advance();
    req_i = 2'b00;
    drive_resp();
    @(negedge clk_i);
    predict();
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_i     = N'($urandom);
      we_i      = N'($urandom);
      be_i      = N'($urandom) == 0 ? '0 : (N*BW)'($urandom);
      addr_i    = {$urandom, $urandom};
      wdata_i   = {$urandom, $urandom};
      sbr_gnt_i = ($urandom_range(0, 3) != 0);
      drive_resp();
      @(negedge clk_i);
      predict();
      checks++;
      if (gnt_o !== e_gnt || sbr_req_o !== (|req_i)) begin
        errors++;
        $display("FAIL rnd_gnt c=%0d got gnt=%b req=%b want gnt=%b req=%b", c, gnt_o, sbr_req_o, e_gnt, |req_i);
      end
      if (e_win >= 0) begin
        checks++;
        if (sbr_addr_o !== addr_i[e_win*32 +: 32] || sbr_we_o !== we_i[e_win] ||
            sbr_be_o !== be_i[e_win*BW +: BW] || sbr_wdata_o !== wdata_i[e_win*DW +: DW]) begin
          errors++;
          $display("FAIL rnd_fwd c=%0d got addr=%h we=%b be=%h wdata=%h want port %0d",
                   c, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o, e_win);
        end
      end
      checks++;
      if (rvalid_o !== e_rvalid || rdata_o !== e_rdata || resp_err_o !== m_err) begin
        errors++;
        $display("FAIL rnd_resp c=%0d got rvalid=%b rdata=%h err=%b want rvalid=%b rdata=%h err=%b",
                 c, rvalid_o, rdata_o, resp_err_o, e_rvalid, e_rdata, m_err);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_stall();
    test_read_resp();
    test_unowned();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
